// File: rtl/ogege_pkg.sv
// ogege_pkg -- shared definitions for the VGA control register block.
//   Register indices on the CPU byte bus, STATUS/CTRL bit positions and
//   the bus handshake state type.
package ogege_pkg;

   // Register indices
   localparam logic [3:0] REG_FG_LO  = 4'h0;
   localparam logic [3:0] REG_FG_HI  = 4'h1;
   localparam logic [3:0] REG_BG_LO  = 4'h2;
   localparam logic [3:0] REG_BG_HI  = 4'h3;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_LINE_LO = 4'h5;
   localparam logic [3:0] REG_LINE_HI = 4'h6;
   localparam logic [3:0] REG_CMP_LO = 4'h7;
   localparam logic [3:0] REG_CMP_HI = 4'h8;
   localparam logic [3:0] REG_FRM_LO = 4'h9;
   localparam logic [3:0] REG_FRM_HI = 4'hA;
   localparam logic [3:0] REG_CTRL   = 4'hB;

   // STATUS bit positions
   localparam int STAT_VBLANK = 0;
   localparam int STAT_FRAME  = 1;
   localparam int STAT_LINE   = 2;

   // CTRL bit positions
   localparam int CTRL_FRAME_IE = 0;
   localparam int CTRL_LINE_IE  = 1;

   // Bus handshake states
   typedef enum logic [1:0] {
      BUS_IDLE     = 2'd0,
      BUS_ACK      = 2'd1,
      BUS_WAIT_LOW = 2'd2
   } bus_state_t;

endpackage

// File: rtl/vga_line_events.sv
// vga_line_events -- raster compare for the control register block.
//   Produces single-cycle event pulses while the raster sits on the last
//   visible column (hcount == H_ACTIVE-1).
// Ports:
//   hcount    in   HSZ  raster column
//   vcount    in   VSZ  raster line
//   cmp       in   9    line compare value
//   frame_evt out  1    last visible line reached
//   line_evt  out  1    compare line reached
module vga_line_events #(
   parameter int HSZ      = 10,
   parameter int VSZ      = 9,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic [HSZ-1:0] hcount,
   input  logic [VSZ-1:0] vcount,
   input  logic [8:0]     cmp,
   output logic           frame_evt,
   output logic           line_evt
);

   logic at_eol;
   logic cmp_visible;

   assign at_eol      = (32'(hcount) == 32'(H_ACTIVE - 1));
   // A compare value past the visible area must never match, even though
   // vcount does reach those values during vertical blanking.
   assign cmp_visible = (32'(cmp) < 32'(V_ACTIVE));

   assign frame_evt = at_eol && (32'(vcount) == 32'(V_ACTIVE - 1));
   assign line_evt  = at_eol && cmp_visible && (32'(vcount) == 32'(cmp));

endmodule

// File: rtl/vga_ctrl_regs.sv
// vga_ctrl_regs -- CPU byte-bus register block for the VGA core.
//   Holds the foreground/background colors, raster status, a line-compare
//   event, a 16-bit frame counter and a level interrupt. Runs on pix_clk.
// Ports:
//   i_clk, i_rstn          pix clock, async active-low reset
//   i_cs, i_stb, i_we      chip select, level strobe, write enable
//   i_addr, i_data         register index and write data
//   o_data, o_data_ready   read data and access acknowledge
//   i_hcount, i_vcount     raster position from vga_core
//   o_fg_color, o_bg_color 12-bit colors
//   o_irq                  level interrupt
module vga_ctrl_regs
   import ogege_pkg::*;
#(
   parameter int          HSZ      = 10,
   parameter int          VSZ      = 9,
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter logic [11:0] FG_RST   = 12'hFFF,
   parameter logic [11:0] BG_RST   = 12'h000
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_cs,
   input  logic           i_stb,
   input  logic           i_we,
   input  logic [3:0]     i_addr,
   input  logic [7:0]     i_data,
   output logic [7:0]     o_data,
   output logic           o_data_ready,
   input  logic [HSZ-1:0] i_hcount,
   input  logic [VSZ-1:0] i_vcount,
   output logic [11:0]    o_fg_color,
   output logic [11:0]    o_bg_color,
   output logic           o_irq
);

   bus_state_t  state;
   logic        stb_q;
   logic        stb_edge;
   logic        access;
   logic        do_wr;
   logic        do_rd;
   logic        clr_status;
   logic        latch_frm;

   logic [11:0] fg;
   logic [11:0] bg;
   logic [8:0]  cmp;
   logic [1:0]  ctrl;
   logic        frame_st;
   logic        line_st;
   logic [15:0] frame_cnt;
   logic [7:0]  shadow;

   logic        frame_evt;
   logic        line_evt;
   logic        vblank;
   logic [15:0] line16;
   logic [7:0]  rd_data;

   vga_line_events #(
      .HSZ      (HSZ),
      .VSZ      (VSZ),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_events (
      .hcount    (i_hcount),
      .vcount    (i_vcount),
      .cmp       (cmp),
      .frame_evt (frame_evt),
      .line_evt  (line_evt)
   );

   // Only a rising strobe seen in IDLE starts an access; stb_q resets high so
   // a strobe already high at reset release is not mistaken for a new one.
   assign stb_edge   = i_stb & ~stb_q;
   assign access     = (state == BUS_IDLE) && stb_edge && i_cs;
   assign do_wr      = access & i_we;
   assign do_rd      = access & ~i_we;
   assign clr_status = do_rd && (i_addr == REG_STATUS);
   assign latch_frm  = do_rd && (i_addr == REG_FRM_LO);

   // Ready is qualified by the live strobe so it drops in the same cycle the
   // strobe falls, and falls asynchronously with the state on reset.
   assign o_data_ready = (state == BUS_ACK) && i_stb;

   assign vblank = (32'(i_vcount) >= 32'(V_ACTIVE));
   assign line16 = 16'(i_vcount);

   assign o_fg_color = fg;
   assign o_bg_color = bg;
   assign o_irq = (frame_st & ctrl[CTRL_FRAME_IE]) | (line_st & ctrl[CTRL_LINE_IE]);

   always_comb begin
      rd_data = '0;
      case (i_addr)
         REG_FG_LO:   rd_data = fg[7:0];
         REG_FG_HI:   rd_data = {4'b0, fg[11:8]};
         REG_BG_LO:   rd_data = bg[7:0];
         REG_BG_HI:   rd_data = {4'b0, bg[11:8]};
         REG_STATUS: begin
            rd_data[STAT_VBLANK] = vblank;
            rd_data[STAT_FRAME]  = frame_st;
            rd_data[STAT_LINE]   = line_st;
         end
         REG_LINE_LO: rd_data = line16[7:0];
         REG_LINE_HI: rd_data = line16[15:8];
         REG_CMP_LO:  rd_data = cmp[7:0];
         REG_CMP_HI:  rd_data = {7'b0, cmp[8]};
         REG_FRM_LO:  rd_data = frame_cnt[7:0];
         REG_FRM_HI:  rd_data = shadow;
         REG_CTRL:    rd_data = {6'b0, ctrl};
         default:     rd_data = '0;
      endcase
   end

   // Bus handshake: IDLE -> ACK -> WAIT_LOW -> IDLE
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= BUS_IDLE;
         stb_q <= 1'b1;
      end else begin
         stb_q <= i_stb;
         case (state)
            BUS_IDLE:     if (access) state <= BUS_ACK;
            BUS_ACK:      if (!i_stb) state <= BUS_WAIT_LOW;
            BUS_WAIT_LOW: state <= BUS_IDLE;
            default:      state <= BUS_IDLE;
         endcase
      end
   end

   // Register file, event stickies and frame counter
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         fg        <= FG_RST;
         bg        <= BG_RST;
         cmp       <= '0;
         ctrl      <= '0;
         frame_st  <= 1'b0;
         line_st   <= 1'b0;
         frame_cnt <= '0;
         shadow    <= '0;
         o_data    <= '0;
      end else begin
         if (do_wr) begin
            case (i_addr)
               REG_FG_LO:  fg[7:0]  <= i_data;
               REG_FG_HI:  fg[11:8] <= i_data[3:0];
               REG_BG_LO:  bg[7:0]  <= i_data;
               REG_BG_HI:  bg[11:8] <= i_data[3:0];
               REG_CMP_LO: cmp[7:0] <= i_data;
               REG_CMP_HI: cmp[8]   <= i_data[0];
               REG_CTRL:   ctrl     <= i_data[1:0];
               default:    ;
            endcase
         end
         if (do_rd) o_data <= rd_data;
         // Reading FRM_LO freezes the high byte so a later FRM_HI read pairs
         // with it even if the counter carries in between.
         if (latch_frm) shadow <= frame_cnt[15:8];
         // An event arriving with a STATUS read clear keeps the bit set.
         frame_st <= frame_evt | (frame_st & ~clr_status);
         line_st  <= line_evt  | (line_st  & ~clr_status);
         if (frame_evt) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vga_ctrl_regs.sv
module tb_vga_ctrl_regs;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_cs;
   logic        i_stb;
   logic        i_we;
   logic [3:0]  i_addr;
   logic [7:0]  i_data;
   logic [7:0]  o_data;
   logic        o_data_ready;
   logic [9:0]  i_hcount;
   logic [8:0]  i_vcount;
   logic [11:0] o_fg_color;
   logic [11:0] o_bg_color;
   logic        o_irq;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int m_fg, m_bg, m_cmp, m_ctrl, m_frames, m_shadow;
   bit m_frame_st, m_line_st;
   int idle_v = 0;

   vga_ctrl_regs dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_cs         (i_cs),
      .i_stb        (i_stb),
      .i_we         (i_we),
      .i_addr       (i_addr),
      .i_data       (i_data),
      .o_data       (o_data),
      .o_data_ready (o_data_ready),
      .i_hcount     (i_hcount),
      .i_vcount     (i_vcount),
      .o_fg_color   (o_fg_color),
      .o_bg_color   (o_bg_color),
      .o_irq        (o_irq)
   );

   always #5 i_clk = ~i_clk;

   function automatic void mdl_reset();
      m_fg = 'hFFF; m_bg = 0; m_cmp = 0; m_ctrl = 0;
      m_frames = 0; m_shadow = 0; m_frame_st = 0; m_line_st = 0;
   endfunction

   function automatic void mdl_write(input int a, input int d);
      case (a)
         0:  m_fg = (m_fg / 256) * 256 + d;
         1:  m_fg = (m_fg % 256) + (d % 16) * 256;
         2:  m_bg = (m_bg / 256) * 256 + d;
         3:  m_bg = (m_bg % 256) + (d % 16) * 256;
         7:  m_cmp = (m_cmp / 256) * 256 + d;
         8:  m_cmp = (m_cmp % 256) + (d % 2) * 256;
         11: m_ctrl = d % 4;
         default: ;
      endcase
   endfunction

   function automatic int mdl_read(input int a, input int v);
      int r;
      case (a)
         0: r = m_fg % 256;
         1: r = m_fg / 256;
         2: r = m_bg % 256;
         3: r = m_bg / 256;
         4: begin
            r = (v >= 480 ? 1 : 0) + (m_frame_st ? 2 : 0) + (m_line_st ? 4 : 0);
            m_frame_st = 0; m_line_st = 0;
         end
         5: r = v % 256;
         6: r = v / 256;
         7: r = m_cmp % 256;
         8: r = m_cmp / 256;
         9: begin r = m_frames % 256; m_shadow = m_frames / 256; end
         10: r = m_shadow;
         11: r = m_ctrl;
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic void mdl_event(input int h, input int v);
      if (h == 639) begin
         if (v == 479) begin
            m_frame_st = 1;
            m_frames = (m_frames + 1) % 65536;
         end
         if (v == m_cmp && m_cmp < 480) m_line_st = 1;
      end
   endfunction

   function automatic logic mdl_irq();
      return (m_frame_st && m_ctrl % 2 == 1) || (m_line_st && m_ctrl / 2 == 1);
   endfunction

   // Bus access starting at posedge+1; strobe held for 'hold' cycles. An
   // optional raster position is applied for one clock at loop index ev_at.
   // Returns the first o_data seen with ready and the number of ready cycles.
   task automatic bus(input logic cs, input logic we, input logic [3:0] a,
                      input logic [7:0] wd, input int hold, input int ev_at,
                      input int ev_h, input int ev_v,
                      output logic [7:0] rd, output int rdy_n);
      rd = 8'hxx;
      rdy_n = 0;
      i_cs = cs; i_we = we; i_addr = a; i_data = wd; i_stb = 1'b1;
      for (int i = 0; i < hold + 2; i++) begin
         if (i == ev_at) begin
            i_hcount = 10'(ev_h);
            i_vcount = 9'(ev_v);
         end
         @(negedge i_clk);
         if (o_data_ready === 1'b1) begin
            if (rdy_n == 0) rd = o_data;
            rdy_n++;
         end
         @(posedge i_clk);
         #1;
         i_hcount = '0;
         i_vcount = 9'(idle_v);
         if (i == hold - 1) begin
            i_stb = 1'b0;
            i_cs = 1'b0;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic raster_pulse(input int h, input int v);
      i_hcount = 10'(h);
      i_vcount = 9'(v);
      @(posedge i_clk);
      #1;
      i_hcount = '0;
      i_vcount = 9'(idle_v);
      mdl_event(h, v);
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      int n, e;
      i_rstn = 1'b0; i_cs = 0; i_stb = 0; i_we = 0; i_addr = 0; i_data = 0;
      i_hcount = 0; i_vcount = 0; idle_v = 0;
      mdl_reset();
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_data_ready !== 1'b0 || o_data !== 8'h00 || o_irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs: ready=%b data=%h irq=%b want 0/00/0", o_data_ready, o_data, o_irq);
      end
      checks++;
      if (o_fg_color !== 12'hFFF || o_bg_color !== 12'h000) begin
         failures++;
         $display("FAIL reset_colors: fg=%h bg=%h want FFF/000", o_fg_color, o_bg_color);
      end
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      for (int a = 0; a < 12; a++) begin
         bus(1, 0, 4'(a), 8'h00, 3, -1, 0, 0, rd, n);
         e = mdl_read(a, idle_v);
         checks++;
         if (rd !== 8'(e) || n != 2) begin
            failures++;
            $display("FAIL reset_read[%0d]: data=%h ready_cycles=%0d want %h/2", a, rd, n, 8'(e));
         end
      end
   endtask

   task automatic test_fg_bg();
      logic [7:0] rd;
      int n, e;
      bus(1, 1, 4'h0, 8'h34, 3, -1, 0, 0, rd, n); mdl_write(0, 'h34);
      bus(1, 1, 4'h1, 8'hA2, 3, -1, 0, 0, rd, n); mdl_write(1, 'hA2);
      checks++;
      if (o_fg_color !== 12'h234 || o_fg_color !== 12'(m_fg)) begin
         failures++;
         $display("FAIL fg_color: got %h want 234", o_fg_color);
      end
      bus(1, 1, 4'hD, 8'h55, 3, -1, 0, 0, rd, n);
      checks++;
      if (n != 2) begin
         failures++;
         $display("FAIL unused_write_ack: ready_cycles=%0d want 2", n);
      end
      bus(1, 0, 4'hD, 8'h00, 3, -1, 0, 0, rd, n);
      checks++;
      if (rd !== 8'h00) begin
         failures++;
         $display("FAIL unused_read: got %h want 00", rd);
      end
      bus(1, 0, 4'h1, 8'h00, 3, -1, 0, 0, rd, n);
      e = mdl_read(1, idle_v);
      checks++;
      if (rd !== 8'(e)) begin
         failures++;
         $display("FAIL fg_hi_read: got %h want %h", rd, 8'(e));
      end
      repeat (2) @(negedge i_clk);
      checks++;
      if (o_data !== 8'(e)) begin
         failures++;
         $display("FAIL data_hold: got %h want %h", o_data, 8'(e));
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_frames();
      logic [7:0] rd;
      int n, e;
      for (int f = 0; f < 3; f++) begin
         raster_pulse(639, 479);
         repeat (2) raster_pulse(int'($urandom_range(0, 638)), int'($urandom_range(0, 511)));
      end
      bus(1, 0, 4'h9, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(9, idle_v);
      checks++;
      if (rd !== 8'(e) || rd !== 8'h03) begin
         failures++;
         $display("FAIL frm_lo: got %h want 03", rd);
      end
      bus(1, 0, 4'hA, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(10, idle_v);
      checks++;
      if (rd !== 8'(e)) begin
         failures++;
         $display("FAIL frm_hi: got %h want %h", rd, 8'(e));
      end
      bus(1, 0, 4'h4, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(4, idle_v);
      checks++;
      if (rd !== 8'(e) || rd[1] !== 1'b1) begin
         failures++;
         $display("FAIL status_frame_set: got %h want %h", rd, 8'(e));
      end
      bus(1, 0, 4'h4, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(4, idle_v);
      checks++;
      if (rd !== 8'(e) || rd[1] !== 1'b0) begin
         failures++;
         $display("FAIL status_frame_clr: got %h want %h", rd, 8'(e));
      end
   endtask

   task automatic test_line_irq();
      logic [7:0] rd;
      int n, e;
      bus(1, 1, 4'h7, 8'd100, 3, -1, 0, 0, rd, n); mdl_write(7, 100);
      bus(1, 1, 4'h8, 8'h00, 3, -1, 0, 0, rd, n); mdl_write(8, 0);
      bus(1, 1, 4'hB, 8'h02, 3, -1, 0, 0, rd, n); mdl_write(11, 2);
      checks++;
      if (o_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_before: got %b want 0", o_irq);
      end
      raster_pulse(639, 100);
      checks++;
      if (o_irq !== mdl_irq() || o_irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_line: got %b want 1", o_irq);
      end
      bus(1, 0, 4'h4, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(4, idle_v);
      checks++;
      if (rd !== 8'(e) || o_irq !== mdl_irq()) begin
         failures++;
         $display("FAIL status_line_clr: data=%h irq=%b want %h/%b", rd, o_irq, 8'(e), mdl_irq());
      end
      // STATUS read and line event on the same clock: set must win
      bus(1, 0, 4'h4, 8'h00, 3, 0, 639, 100, rd, n);
      e = mdl_read(4, 100);
      mdl_event(639, 100);
      checks++;
      if (rd !== 8'(e) || o_irq !== 1'b1) begin
         failures++;
         $display("FAIL set_wins: data=%h irq=%b want %h/1", rd, o_irq, 8'(e));
      end
      bus(1, 0, 4'h4, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(4, idle_v);
      // Compare value beyond the last visible line never matches
      bus(1, 1, 4'h7, 8'hF4, 3, -1, 0, 0, rd, n); mdl_write(7, 'hF4);
      bus(1, 1, 4'h8, 8'h01, 3, -1, 0, 0, rd, n); mdl_write(8, 1);
      raster_pulse(639, 500);
      checks++;
      if (o_irq !== mdl_irq() || o_irq !== 1'b0) begin
         failures++;
         $display("FAIL cmp_beyond: irq=%b want 0", o_irq);
      end
   endtask

   task automatic test_handshake();
      logic [7:0] rd;
      int n, e;
      bus(0, 1, 4'h2, 8'h77, 3, -1, 0, 0, rd, n);
      checks++;
      if (n != 0 || o_bg_color !== 12'(m_bg)) begin
         failures++;
         $display("FAIL no_cs: ready_cycles=%0d bg=%h want 0/%h", n, o_bg_color, 12'(m_bg));
      end
      bus(1, 1, 4'h0, 8'h5A, 20, -1, 0, 0, rd, n); mdl_write(0, 'h5A);
      checks++;
      if (n != 19 || o_fg_color !== 12'(m_fg)) begin
         failures++;
         $display("FAIL long_write: ready_cycles=%0d fg=%h want 19/%h", n, o_fg_color, 12'(m_fg));
      end
      // Long STATUS read with a frame event mid-hold: clear happens only once
      bus(1, 0, 4'h4, 8'h00, 20, 10, 639, 479, rd, n);
      e = mdl_read(4, idle_v);
      mdl_event(639, 479);
      checks++;
      if (rd !== 8'(e) || n != 19) begin
         failures++;
         $display("FAIL long_read: data=%h ready_cycles=%0d want %h/19", rd, n, 8'(e));
      end
      bus(1, 0, 4'h4, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(4, idle_v);
      checks++;
      if (rd !== 8'(e) || rd[1] !== 1'b1) begin
         failures++;
         $display("FAIL single_clear: got %h want %h", rd, 8'(e));
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd;
      int n, e, cnt;
      i_cs = 1; i_we = 1; i_addr = 4'h0; i_data = 8'h12; i_stb = 1;
      @(posedge i_clk);
      #1;
      checks++;
      if (o_data_ready !== 1'b1) begin
         failures++;
         $display("FAIL ack_before_reset: ready=%b want 1", o_data_ready);
      end
      i_rstn = 1'b0;
      #1;
      mdl_reset();
      checks++;
      if (o_data_ready !== 1'b0 || o_fg_color !== 12'hFFF) begin
         failures++;
         $display("FAIL async_reset: ready=%b fg=%h want 0/FFF", o_data_ready, o_fg_color);
      end
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;
      cnt = 0;
      repeat (5) begin
         @(negedge i_clk);
         if (o_data_ready === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 0 || o_fg_color !== 12'hFFF) begin
         failures++;
         $display("FAIL stb_through_reset: ready_cycles=%0d fg=%h want 0/FFF", cnt, o_fg_color);
      end
      @(posedge i_clk);
      #1;
      i_stb = 0; i_cs = 0;
      repeat (2) @(posedge i_clk);
      #1;
      for (int f = 0; f < 255; f++) raster_pulse(639, 479);
      bus(1, 0, 4'h9, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(9, idle_v);
      checks++;
      if (rd !== 8'(e) || rd !== 8'hFF) begin
         failures++;
         $display("FAIL preload_frm_lo: got %h want FF", rd);
      end
      raster_pulse(639, 479);
      bus(1, 0, 4'hA, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(10, idle_v);
      checks++;
      if (rd !== 8'(e) || rd !== 8'h00) begin
         failures++;
         $display("FAIL shadow_frm_hi: got %h want 00", rd);
      end
      bus(1, 0, 4'h9, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(9, idle_v);
      bus(1, 0, 4'hA, 8'h00, 3, -1, 0, 0, rd, n); e = mdl_read(10, idle_v);
      checks++;
      if (rd !== 8'(e) || rd !== 8'h01) begin
         failures++;
         $display("FAIL frm_hi_carry: got %h want 01", rd);
      end
   endtask

   task automatic test_random();
      logic [7:0] rd;
      int n, e, op, a, d, h, v;
      for (int k = 0; k < 200; k++) begin
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 255));
            bus(1, 1, 4'(a), 8'(d), 3, -1, 0, 0, rd, n);
            mdl_write(a, d);
            checks++;
            if (n != 2) begin
               failures++;
               $display("FAIL rnd_write_ack[%0d]: ready_cycles=%0d want 2", k, n);
            end
         end else if (op == 1) begin
            a = int'($urandom_range(0, 15));
            idle_v = int'($urandom_range(0, 511));
            i_vcount = 9'(idle_v);
            bus(1, 0, 4'(a), 8'h00, 3, -1, 0, 0, rd, n);
            e = mdl_read(a, idle_v);
            checks++;
            if (rd !== 8'(e)) begin
               failures++;
               $display("FAIL rnd_read[%0d] reg %0d: got %h want %h", k, a, rd, 8'(e));
            end
         end else begin
            h = ($urandom_range(0, 1) == 1) ? 639 : int'($urandom_range(0, 1023));
            case ($urandom_range(0, 2))
               0: v = 479;
               1: v = m_cmp % 512;
               default: v = int'($urandom_range(0, 511));
            endcase
            raster_pulse(h, v);
         end
         checks++;
         if (o_irq !== mdl_irq() || o_fg_color !== 12'(m_fg) || o_bg_color !== 12'(m_bg)) begin
            failures++;
            $display("FAIL rnd_state[%0d]: irq=%b fg=%h bg=%h want %b/%h/%h",
                     k, o_irq, o_fg_color, o_bg_color, mdl_irq(), 12'(m_fg), 12'(m_bg));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fg_bg();
      test_frames();
      test_line_irq();
      test_handshake();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
